uart_tx_dev: RTL and testbench

Memory-mapped UART transmitter peripheral, attached to the system bridge as a third device beside the two timers. It uses the same responder-side register interface as the timers: word address, write enable, write data, read data and an interrupt line. CPU writes bytes into an internal FIFO, and the block serialises them as 8N1 frames on `txd`. It raises an interrupt when the FIFO has drained and the line is idle.

---
 rtl/uart_tx_pkg.sv | 30 +++
 rtl/uart_tx_dev_if.sv | 15 +
 rtl/sync_fifo.sv | 54 +++++
 rtl/uart_tx_dev.sv | 167 ++++++++++++++++
 tb/tb_uart_tx_dev.sv | 323 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/uart_tx_pkg.sv
// Shared definitions for the memory-mapped UART transmitter.
package uart_tx_pkg;

  // Transmit FSM states.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } state_t;

  // Register word offsets, decoded from ADD_I[3:2].
  localparam logic [1:0] REG_DATA = 2'd0;
  localparam logic [1:0] REG_CTRL = 2'd1;
  localparam logic [1:0] REG_DIV  = 2'd2;
  localparam logic [1:0] REG_STAT = 2'd3;

  // CTRL bit positions.
  localparam int unsigned CTRL_EN      = 0;
  localparam int unsigned CTRL_IM      = 1;
  localparam int unsigned CTRL_OVF_CLR = 2;

  // STATUS bit positions.
  localparam int unsigned STAT_BUSY      = 0;
  localparam int unsigned STAT_FULL      = 1;
  localparam int unsigned STAT_EMPTY     = 2;
  localparam int unsigned STAT_OVF       = 3;
  localparam int unsigned STAT_COUNT_LSB = 8;

endpackage

// File: rtl/uart_tx_dev_if.sv
// Responder-side register bus shared with the timer devices.
// Protocol: there is no valid/ready pair. A write happens at every rising
// clk edge where WE_I=1, to the register selected by ADD_I[3:2]; the device
// never stalls. DAT_O is a combinational function of ADD_I and register state,
// and IRQ_O is a level derived from register state.
interface uart_tx_dev_if;
  logic [3:0]  ADD_I;
  logic        WE_I;
  logic [31:0] DAT_I;
  logic [31:0] DAT_O;
  logic        IRQ_O;

  modport master (output ADD_I, WE_I, DAT_I, input DAT_O, IRQ_O);
  modport slave  (input ADD_I, WE_I, DAT_I, output DAT_O, IRQ_O);
endinterface

// File: rtl/sync_fifo.sv
// Generic synchronous FIFO with occupancy count. A push while full is only
// accepted when a pop happens in the same cycle, so the count stays put.
module sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   push_i,
  input  logic                   pop_i,
  input  logic [WIDTH-1:0]       din_i,
  output logic [WIDTH-1:0]       dout_o,
  output logic                   full_o,
  output logic                   empty_o,
  output logic [$clog2(DEPTH):0] count_o
);
  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q;
  logic [AW-1:0]    rd_ptr_q;
  logic [AW:0]      count_q;
  logic             do_push;
  logic             do_pop;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == (AW+1)'(DEPTH));
  assign count_o = count_q;
  assign dout_o  = mem_q[rd_ptr_q];
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);

  // Storage array; contents need no reset because the pointers define validity.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= din_i;
  end

  // Pointers and occupancy.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end
endmodule

// File: rtl/uart_tx_dev.sv
// UART 8N1 transmitter bus device: register file, FIFO, baud/bit counters and
// the frame FSM. Each bit lasts DIV+1 clocks, DIV being latched per frame.
module uart_tx_dev
  import uart_tx_pkg::*;
#(
  parameter int unsigned DEPTH     = 8,
  parameter logic [15:0] DIV_RESET = 16'd433
) (
  input  logic         clk,
  input  logic         reset,
  uart_tx_dev_if.slave bus,
  output logic         txd,
  output state_t       dbg_state_o
);
  localparam int unsigned CW = $clog2(DEPTH) + 1;

  logic          en_q, im_q, ovf_q;
  logic [15:0]   div_q;
  state_t        state_q;
  logic          txd_q;
  logic [7:0]    shift_q;
  logic [15:0]   div_lat_q;
  logic [15:0]   baud_q;
  logic [2:0]    bit_cnt_q;

  logic [1:0]    reg_sel;
  logic          wr_data, wr_ctrl, wr_div;
  logic          fifo_full, fifo_empty;
  logic [7:0]    fifo_dout;
  logic [CW-1:0] fifo_count;
  logic          busy, baud_done, frame_end, pop, push;
  logic [31:0]   rdata;
  logic          unused_bits;

  assign reg_sel   = bus.ADD_I[3:2];
  assign wr_data   = bus.WE_I && (reg_sel == REG_DATA);
  assign wr_ctrl   = bus.WE_I && (reg_sel == REG_CTRL);
  assign wr_div    = bus.WE_I && (reg_sel == REG_DIV);
  assign busy      = (state_q != ST_IDLE);
  assign baud_done = (baud_q == 16'd0);
  assign frame_end = (state_q == ST_STOP) && baud_done;
  // A new frame starts from idle or directly out of the last stop-bit clock.
  assign pop       = en_q && !fifo_empty && ((state_q == ST_IDLE) || frame_end);
  // A write to a full FIFO still lands when the same cycle frees a slot.
  assign push      = wr_data && (!fifo_full || pop);
  assign unused_bits = ^{bus.ADD_I[1:0], bus.DAT_I[31:16]};

  sync_fifo #(.WIDTH(8), .DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .push_i  (push),
    .pop_i   (pop),
    .din_i   (bus.DAT_I[7:0]),
    .dout_o  (fifo_dout),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  // Control, divisor and overflow registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      en_q  <= 1'b0;
      im_q  <= 1'b0;
      ovf_q <= 1'b0;
      div_q <= DIV_RESET;
    end else begin
      if (wr_ctrl) begin
        en_q <= bus.DAT_I[CTRL_EN];
        im_q <= bus.DAT_I[CTRL_IM];
      end
      if (wr_div) div_q <= bus.DAT_I[15:0];
      if (wr_data && fifo_full && !pop) ovf_q <= 1'b1;
      else if (wr_ctrl && bus.DAT_I[CTRL_OVF_CLR]) ovf_q <= 1'b0;
    end
  end

  // Frame FSM: start bit, 8 data bits LSB first, stop bit; txd is registered.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      txd_q     <= 1'b1;
      shift_q   <= 8'd0;
      div_lat_q <= 16'd0;
      baud_q    <= 16'd0;
      bit_cnt_q <= 3'd0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (pop) begin
            state_q   <= ST_START;
            txd_q     <= 1'b0;
            shift_q   <= fifo_dout;
            div_lat_q <= div_q;
            baud_q    <= div_q;
          end
        end
        ST_START: begin
          if (baud_done) begin
            state_q   <= ST_DATA;
            txd_q     <= shift_q[0];
            baud_q    <= div_lat_q;
            bit_cnt_q <= 3'd0;
          end else begin
            baud_q <= baud_q - 16'd1;
          end
        end
        ST_DATA: begin
          if (baud_done) begin
            baud_q <= div_lat_q;
            if (bit_cnt_q == 3'd7) begin
              state_q <= ST_STOP;
              txd_q   <= 1'b1;
            end else begin
              bit_cnt_q <= bit_cnt_q + 3'd1;
              shift_q   <= {1'b0, shift_q[7:1]};
              txd_q     <= shift_q[1];
            end
          end else begin
            baud_q <= baud_q - 16'd1;
          end
        end
        ST_STOP: begin
          if (baud_done) begin
            if (pop) begin
              state_q   <= ST_START;
              txd_q     <= 1'b0;
              shift_q   <= fifo_dout;
              div_lat_q <= div_q;
              baud_q    <= div_q;
            end else begin
              state_q <= ST_IDLE;
            end
          end else begin
            baud_q <= baud_q - 16'd1;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  // Combinational read mux; unmapped bits read 0.
  always_comb begin
    rdata = 32'd0;
    case (reg_sel)
      REG_CTRL: begin
        rdata[CTRL_EN] = en_q;
        rdata[CTRL_IM] = im_q;
      end
      REG_DIV:  rdata[15:0] = div_q;
      REG_STAT: begin
        rdata[STAT_BUSY]              = busy;
        rdata[STAT_FULL]              = fifo_full;
        rdata[STAT_EMPTY]             = fifo_empty;
        rdata[STAT_OVF]               = ovf_q;
        rdata[STAT_COUNT_LSB +: 4]    = 4'(fifo_count);
      end
      default: rdata = 32'd0;
    endcase
  end

  assign bus.DAT_O   = rdata;
  assign bus.IRQ_O   = im_q && fifo_empty && !busy;
  assign txd         = txd_q;
  assign dbg_state_o = state_q;
endmodule

// File: tb/tb_uart_tx_dev.sv
// Bench for uart_tx_dev: register checks plus line waveforms compared with a
// frame-level model of the serial output.
module tb_uart_tx_dev;
  import uart_tx_pkg::*;

  localparam logic [3:0] A_DATA = 4'h0;
  localparam logic [3:0] A_CTRL = 4'h4;
  localparam logic [3:0] A_DIV  = 4'h8;
  localparam logic [3:0] A_STAT = 4'hC;
  localparam int WL = 512;

  logic   clk = 1'b0;
  logic   reset = 1'b1;
  logic   txd;
  state_t dbg_state;
  int     total = 0;
  int     bad = 0;

  uart_tx_dev_if bus();

  uart_tx_dev #(.DEPTH(8), .DIV_RESET(16'd433)) dut (
    .clk         (clk),
    .reset       (reset),
    .bus         (bus.slave),
    .txd         (txd),
    .dbg_state_o (dbg_state)
  );

  // Clock and global time limit.
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  // ---------------- driver tasks ----------------
  task automatic bus_write(input logic [3:0] a, input logic [31:0] d);
    bus.ADD_I = a; bus.DAT_I = d; bus.WE_I = 1'b1;
    @(posedge clk); #1;
    bus.WE_I = 1'b0; bus.ADD_I = A_STAT; bus.DAT_I = '0;
  endtask

  task automatic bus_read(input logic [3:0] a, output logic [31:0] d);
    bus.ADD_I = a; #1; d = bus.DAT_O;
  endtask

  task automatic do_reset();
    reset = 1'b1; @(posedge clk); #1; reset = 1'b0;
  endtask

  // Sample txd, BUSY and IRQ_O at each falling edge for n cycles.
  task automatic capture(input int n, output logic [WL-1:0] wt,
                         output logic [WL-1:0] wb, output logic [WL-1:0] wi);
    wt = '0; wb = '0; wi = '0; bus.ADD_I = A_STAT;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      wt[i] = txd; wb[i] = bus.DAT_O[0]; wi[i] = bus.IRQ_O;
    end
  endtask

  function automatic int first_diff(input logic [WL-1:0] a, input logic [WL-1:0] b);
    for (int i = 0; i < WL; i++) if (a[i] !== b[i]) return i;
    return 0;
  endfunction

  // Reference line model: after `lead` idle samples, frames {stop,byte,start}
  // follow each other, every bit lasting d[f]+1 samples; otherwise the line idles high.
  function automatic void model_line(input int n, input int lead, input int nb,
                                     input logic [7:0] b[16], input int d[16],
                                     output logic [WL-1:0] wt, output logic [WL-1:0] wb);
    int t; int f; logic [9:0] fr;
    wt = '0; wb = '0;
    for (int i = 0; i < n; i++) begin
      wt[i] = 1'b1;
      t = i - lead; f = 0;
      while (t >= 0 && f < nb && t >= 10 * (d[f] + 1)) begin
        t = t - 10 * (d[f] + 1); f++;
      end
      if (t >= 0 && f < nb) begin
        fr = {1'b1, b[f], 1'b0};
        wt[i] = fr[t / (d[f] + 1)];
        wb[i] = 1'b1;
      end
    end
  endfunction

  // ---------------- tests ----------------
  task automatic test_reset();
    logic [31:0] r;
    repeat (2) @(posedge clk); #1; reset = 1'b0;
    bus_read(A_CTRL, r); total++;
    if (r !== 32'h0) begin bad++; $display("FAIL reset_ctrl: got %h expected %h", r, 32'h0); end
    bus_read(A_DIV, r); total++;
    if (r !== 32'd433) begin bad++; $display("FAIL reset_div: got %h expected %h", r, 32'd433); end
    bus_read(4'hD, r); total++;
    if (r !== 32'h4) begin bad++; $display("FAIL reset_status: got %h expected %h", r, 32'h4); end
    bus_read(A_DATA, r); total++;
    if (r !== 32'h0) begin bad++; $display("FAIL reset_data_rd: got %h expected %h", r, 32'h0); end
    total++;
    if (txd !== 1'b1) begin bad++; $display("FAIL reset_txd: got %b expected 1", txd); end
    total++;
    if (bus.IRQ_O !== 1'b0) begin bad++; $display("FAIL reset_irq: got %b expected 0", bus.IRQ_O); end
    total++;
    if (dbg_state !== ST_IDLE) begin bad++; $display("FAIL reset_state: got %0d expected %0d", dbg_state, ST_IDLE); end
    bus_write(A_CTRL, 32'hFFFF_FFFF);
    bus_read(A_CTRL, r); total++;
    if (r !== 32'h3) begin bad++; $display("FAIL ctrl_rb: got %h expected %h", r, 32'h3); end
    total++;
    if (bus.IRQ_O !== 1'b1) begin bad++; $display("FAIL irq_idle_masked_on: got %b expected 1", bus.IRQ_O); end
    bus_write(A_DIV, 32'hABCD_1234);
    bus_read(A_DIV, r); total++;
    if (r !== 32'h1234) begin bad++; $display("FAIL div_rb: got %h expected %h", r, 32'h1234); end
    bus_write(A_STAT, 32'hFFFF_FFFF);
    bus_read(A_STAT, r); total++;
    if (r !== 32'h4) begin bad++; $display("FAIL status_wr_ignored: got %h expected %h", r, 32'h4); end
    bus_write(A_CTRL, 32'h0);
    total++;
    if (bus.IRQ_O !== 1'b0) begin bad++; $display("FAIL irq_masked_off: got %b expected 0", bus.IRQ_O); end
  endtask

  task automatic test_single_frame();
    logic [WL-1:0] wt, wb, wi, et, eb;
    logic [7:0] b[16]; int d[16]; logic [31:0] r; int k;
    do_reset();
    b[0] = 8'hA5; d[0] = 3;
    bus_write(A_DIV, 32'd3);
    bus_write(A_CTRL, 32'h1);
    bus_write(A_DATA, 32'hA5);
    capture(48, wt, wb, wi);
    model_line(48, 1, 1, b, d, et, eb);
    total++;
    if (wt !== et) begin
      bad++; k = first_diff(wt, et);
      $display("FAIL single_txd: sample %0d got %b expected %b", k, wt[k], et[k]);
    end
    total++;
    if (wb !== eb) begin
      bad++; k = first_diff(wb, eb);
      $display("FAIL single_busy: sample %0d got %b expected %b", k, wb[k], eb[k]);
    end
    bus_read(A_STAT, r); total++;
    if (r !== 32'h4) begin bad++; $display("FAIL single_status_end: got %h expected %h", r, 32'h4); end
  endtask

  task automatic test_overflow();
    logic [31:0] r;
    do_reset();
    for (int i = 0; i < 9; i++) bus_write(A_DATA, 32'($urandom_range(0, 255)));
    bus_read(A_STAT, r); total++;
    if (r !== 32'h0000_080A) begin bad++; $display("FAIL ovf_status: got %h expected %h", r, 32'h0000_080A); end
    bus_write(A_CTRL, 32'h4);
    bus_read(A_STAT, r); total++;
    if (r !== 32'h0000_0802) begin bad++; $display("FAIL ovf_clear: got %h expected %h", r, 32'h0000_0802); end
    bus_read(A_CTRL, r); total++;
    if (r !== 32'h0) begin bad++; $display("FAIL ovf_ctrl_rb: got %h expected %h", r, 32'h0); end
  endtask

  task automatic test_back_to_back();
    logic [WL-1:0] wt, wb, wi, et, eb, ei;
    logic [7:0] b[16]; int d[16]; int k;
    do_reset();
    bus_write(A_DIV, 32'd1);
    for (int i = 0; i < 3; i++) begin
      b[i] = 8'($urandom_range(0, 255)); d[i] = 1;
      bus_write(A_DATA, {24'd0, b[i]});
    end
    bus_write(A_CTRL, 32'h3);
    capture(70, wt, wb, wi);
    model_line(70, 1, 3, b, d, et, eb);
    ei = '0;
    for (int i = 61; i < 70; i++) ei[i] = 1'b1;
    total++;
    if (wt !== et) begin
      bad++; k = first_diff(wt, et);
      $display("FAIL b2b_txd: sample %0d got %b expected %b", k, wt[k], et[k]);
    end
    total++;
    if (wb !== eb) begin
      bad++; k = first_diff(wb, eb);
      $display("FAIL b2b_busy: sample %0d got %b expected %b", k, wb[k], eb[k]);
    end
    total++;
    if (wi !== ei) begin
      bad++; k = first_diff(wi, ei);
      $display("FAIL b2b_irq: sample %0d got %b expected %b", k, wi[k], ei[k]);
    end
  endtask

  task automatic test_push_on_pop();
    logic [WL-1:0] wt, wb, wi, et, eb;
    logic [7:0] b[16]; int d[16]; logic [31:0] r; int k;
    do_reset();
    bus_write(A_DIV, 32'd0);
    for (int i = 0; i < 9; i++) begin b[i] = 8'($urandom_range(0, 255)); d[i] = 0; end
    for (int i = 0; i < 8; i++) bus_write(A_DATA, {24'd0, b[i]});
    bus_write(A_CTRL, 32'h1);
    bus_write(A_DATA, {24'd0, b[8]});
    bus_read(A_STAT, r); total++;
    if (r !== 32'h0000_0803) begin bad++; $display("FAIL pushpop_status: got %h expected %h", r, 32'h0000_0803); end
    capture(95, wt, wb, wi);
    model_line(95, 0, 9, b, d, et, eb);
    total++;
    if (wt !== et) begin
      bad++; k = first_diff(wt, et);
      $display("FAIL pushpop_txd: sample %0d got %b expected %b", k, wt[k], et[k]);
    end
  endtask

  task automatic test_en_clear();
    logic [WL-1:0] wt, wb, wi, et, eb;
    logic [7:0] b[16]; int d[16]; logic [31:0] r; int k;
    do_reset();
    bus_write(A_DIV, 32'd0);
    b[0] = 8'($urandom_range(0, 255)); d[0] = 0;
    bus_write(A_DATA, {24'd0, b[0]});
    bus_write(A_DATA, 32'h5A);
    bus_write(A_CTRL, 32'h1);
    bus_write(A_CTRL, 32'h0);
    capture(16, wt, wb, wi);
    model_line(16, 0, 1, b, d, et, eb);
    total++;
    if (wt !== et) begin
      bad++; k = first_diff(wt, et);
      $display("FAIL enclr_txd: sample %0d got %b expected %b", k, wt[k], et[k]);
    end
    bus_read(A_STAT, r); total++;
    if (r !== 32'h0000_0100) begin bad++; $display("FAIL enclr_status: got %h expected %h", r, 32'h0000_0100); end
  endtask

  task automatic test_div_midframe();
    logic [WL-1:0] wt, wb, wi, et, eb;
    logic [7:0] b[16]; int d[16]; int k;
    do_reset();
    bus_write(A_DIV, 32'd1);
    b[0] = 8'($urandom_range(0, 255)); b[1] = 8'($urandom_range(0, 255));
    d[0] = 1; d[1] = 3;
    bus_write(A_DATA, {24'd0, b[0]});
    bus_write(A_DATA, {24'd0, b[1]});
    bus_write(A_CTRL, 32'h1);
    bus_write(A_DIV, 32'd3);
    capture(64, wt, wb, wi);
    model_line(64, 0, 2, b, d, et, eb);
    total++;
    if (wt !== et) begin
      bad++; k = first_diff(wt, et);
      $display("FAIL divmid_txd: sample %0d got %b expected %b", k, wt[k], et[k]);
    end
  endtask

  task automatic test_reset_mid_frame();
    logic [WL-1:0] wt, wb, wi;
    logic [31:0] r;
    do_reset();
    bus_write(A_DIV, 32'd3);
    bus_write(A_CTRL, 32'h3);
    bus_write(A_DATA, 32'h00);
    bus_write(A_DATA, 32'h3C);
    repeat (7) @(posedge clk); #1;
    total++;
    if (dbg_state !== ST_DATA || txd !== 1'b0) begin
      bad++; $display("FAIL rstmid_pre: state %0d txd %b expected state %0d txd 0", dbg_state, txd, ST_DATA);
    end
    reset = 1'b1; @(posedge clk); #1; reset = 1'b0;
    total++;
    if (txd !== 1'b1) begin bad++; $display("FAIL rstmid_txd: got %b expected 1", txd); end
    bus_read(A_STAT, r); total++;
    if (r !== 32'h4) begin bad++; $display("FAIL rstmid_status: got %h expected %h", r, 32'h4); end
    capture(60, wt, wb, wi);
    total++;
    if (wt[59:0] !== {60{1'b1}} || wb[59:0] !== 60'd0) begin
      bad++; $display("FAIL rstmid_quiet: txd %h busy %h expected all-ones/zero", wt[59:0], wb[59:0]);
    end
  endtask

  task automatic test_random();
    logic [WL-1:0] wt, wb, wi, et, eb;
    logic [7:0] b[16]; int d[16]; logic [31:0] r; int k; int dv; int nb; int n;
    do_reset();
    for (int rnd = 0; rnd < 6; rnd++) begin
      dv = $urandom_range(0, 3); nb = $urandom_range(1, 4);
      bus_write(A_CTRL, 32'h0);
      bus_write(A_DIV, dv);
      for (int i = 0; i < nb; i++) begin
        b[i] = 8'($urandom_range(0, 255)); d[i] = dv;
        bus_write(A_DATA, {24'd0, b[i]});
      end
      bus_write(A_CTRL, 32'h1);
      n = 1 + nb * 10 * (dv + 1) + 4;
      capture(n, wt, wb, wi);
      model_line(n, 1, nb, b, d, et, eb);
      total++;
      if (wt !== et) begin
        bad++; k = first_diff(wt, et);
        $display("FAIL rand%0d_txd: sample %0d got %b expected %b", rnd, k, wt[k], et[k]);
      end
      total++;
      if (wb !== eb) begin
        bad++; k = first_diff(wb, eb);
        $display("FAIL rand%0d_busy: sample %0d got %b expected %b", rnd, k, wb[k], eb[k]);
      end
      bus_read(A_STAT, r); total++;
      if (r !== 32'h4) begin bad++; $display("FAIL rand%0d_status: got %h expected %h", rnd, r, 32'h4); end
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    bus.WE_I = 1'b0; bus.ADD_I = A_STAT; bus.DAT_I = '0;
    test_reset();
    test_single_frame();
    test_overflow();
    test_back_to_back();
    test_push_on_pop();
    test_en_clear();
    test_div_midframe();
    test_reset_mid_frame();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
